tj_trigger_fsm: RTL

- Upstream neighbour of the 20-bit Tj LFSR counter.
- Watches the plaintext stream entering the AES core and recognises a fixed ordered sequence of four 128-bit plaintext patterns.
- On recognising the full sequence, asserts Tj_Trig, which enables LFSR stepping.
- Adds an inter-match timeout so a sequence spread too far apart in time does not arm the trigger.

---
 rtl/tj_pkg.sv | 46 ++++
 rtl/tj_pt_match.sv | 21 ++
 rtl/tj_trigger_fsm.sv | 90 +++++++++
 3 files changed

// File: rtl/tj_pkg.sv
// Shared constants for the Tj trigger: the arming plaintext sequence,
// FSM state encoding and small helpers used by the matcher and the FSM.
package tj_pkg;

  localparam int unsigned PT_W    = 128;
  localparam int unsigned STAGE_W = 2;
  localparam int unsigned ST_W    = 3;

  localparam logic [PT_W-1:0] P0 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [PT_W-1:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [PT_W-1:0] P2 = 128'h0;
  localparam logic [PT_W-1:0] P3 = 128'h1;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_S1    = 3'd1,
    ST_S2    = 3'd2,
    ST_S3    = 3'd3,
    ST_ARMED = 3'd4
  } tj_state_e;

  // Pattern the FSM waits for at a given number of matches so far.
  function automatic logic [PT_W-1:0] expected_pattern(input logic [STAGE_W-1:0] idx);
    logic [PT_W-1:0] pat;
    case (idx)
      2'd0:    pat = P0;
      2'd1:    pat = P1;
      2'd2:    pat = P2;
      default: pat = P3;
    endcase
    return pat;
  endfunction

  // Successor state on an in-order match; S3 arms the trigger.
  function automatic tj_state_e advance_state(input tj_state_e s);
    tj_state_e nxt;
    case (s)
      ST_IDLE: nxt = ST_S1;
      ST_S1:   nxt = ST_S2;
      ST_S2:   nxt = ST_S3;
      default: nxt = ST_ARMED;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/tj_pt_match.sv
// Combinational plaintext comparator: full-width equality against the pattern
// expected at the current stage, plus a separate check for the restart pattern.
module tj_pt_match
  import tj_pkg::*;
(
  input  logic [PT_W-1:0]    state,
  input  logic [STAGE_W-1:0] stage_idx,
  output logic               hit_expected,
  output logic               hit_p0
);

  logic [PT_W-1:0] w_expected;

  always_comb begin
    w_expected = expected_pattern(stage_idx);
  end

  assign hit_expected = (state == w_expected);
  assign hit_p0       = (state == P0);

endmodule

// File: rtl/tj_trigger_fsm.sv
// Recognises the ordered four-plaintext arming sequence with an inter-match
// timeout and raises a sticky trigger (plus a one-cycle pulse) for the LFSR.
module tj_trigger_fsm
  import tj_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS = 4,
  parameter int unsigned TIMEOUT      = 1024,
  parameter int unsigned CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PT_W-1:0]    state,
  input  logic               pt_valid,
  output logic               Tj_Trig,
  output logic [STAGE_W-1:0] stage,
  output logic               armed_pulse
);

  // Parameter sanity: the pattern table is fixed and the counter must hold TIMEOUT.
  if (NUM_PATTERNS != 4) begin : g_bad_num_patterns
    $error("tj_trigger_fsm: NUM_PATTERNS must be 4");
  end
  if ((TIMEOUT < 1) || (TIMEOUT > 65535) || ((64'd1 << CNT_W) <= 64'(TIMEOUT))) begin : g_bad_timeout
    $error("tj_trigger_fsm: TIMEOUT out of range for CNT_W");
  end

  tj_state_e        r_state;
  logic [CNT_W-1:0] r_cnt;

  logic w_hit_expected;
  logic w_hit_p0;
  logic w_timeout;

  tj_pt_match u_match (
    .state        (state),
    .stage_idx    (stage),
    .hit_expected (w_hit_expected),
    .hit_p0       (w_hit_p0)
  );

  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT));

  // FSM, timeout counter and registered outputs; rst overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      stage       <= '0;
      Tj_Trig     <= 1'b0;
      armed_pulse <= 1'b0;
    end else begin
      armed_pulse <= 1'b0;
      case (r_state)
        ST_ARMED: begin
          r_cnt <= '0;
        end
        default: begin
          if (pt_valid) begin
            // A valid plaintext is always evaluated, even on the timeout cycle.
            r_cnt <= '0;
            if (w_hit_expected) begin
              r_state <= advance_state(r_state);
              if (r_state == ST_S3) begin
                Tj_Trig     <= 1'b1;
                armed_pulse <= 1'b1;
              end else begin
                stage <= stage + STAGE_W'(1);
              end
            end else if (w_hit_p0) begin
              r_state <= ST_S1;
              stage   <= STAGE_W'(1);
            end else begin
              r_state <= ST_IDLE;
              stage   <= '0;
            end
          end else if (r_state != ST_IDLE) begin
            if (w_timeout) begin
              r_state <= ST_IDLE;
              stage   <= '0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
      endcase
    end
  end

endmodule
